// File: rtl/risc_pkg.sv
// risc_pkg: definitions shared by the execute stage of the RISC pipeline.
//   - WIDTH_DEF / MUL_CYCLES_DEF : default datapath width and multiplier iteration count
//   - FS_* localparams           : function-select opcodes
//   - state_t                    : execute-stage sequencer states
//   - flags_t                    : N/Z/C/V status bundle
package risc_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int MUL_CYCLES_DEF = 16;

  localparam logic [4:0] FS_MOVA = 5'b00000;
  localparam logic [4:0] FS_INC  = 5'b00001;
  localparam logic [4:0] FS_ADD  = 5'b00010;
  localparam logic [4:0] FS_SUB  = 5'b00101;
  localparam logic [4:0] FS_DEC  = 5'b00110;
  localparam logic [4:0] FS_AND  = 5'b01000;
  localparam logic [4:0] FS_OR   = 5'b01010;
  localparam logic [4:0] FS_XOR  = 5'b01100;
  localparam logic [4:0] FS_NOT  = 5'b01110;
  localparam logic [4:0] FS_MOVB = 5'b10000;
  localparam logic [4:0] FS_LSR  = 5'b10100;
  localparam logic [4:0] FS_LSL  = 5'b11000;
  localparam logic [4:0] FS_MUL  = 5'b11100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MUL_RUN = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Flags for results that carry no arithmetic information (logic, moves, product).
  function automatic flags_t plain_flags(input logic msb, input logic zero);
    flags_t f;
    f.n = msb;
    f.z = zero;
    f.c = 1'b0;
    f.v = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/risc_exec_unit_mul.sv
// risc_mul_iter: unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load operands, clear product and counter
//   run        : perform one shift-add step
//   a, b       : MUL_CYCLES-bit unsigned operands
//   done       : high during the step that completes the product
//   product    : WIDTH-bit product register (final after the done step)
module risc_mul_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  run,
  input  logic [MUL_CYCLES-1:0] a,
  input  logic [MUL_CYCLES-1:0] b,
  output logic                  done,
  output logic [WIDTH-1:0]      product
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mcand_r;
  logic [MUL_CYCLES-1:0] mplier_r;
  logic [WIDTH-1:0]      prod_r;
  logic [CW-1:0]         cnt_r;

  assign done    = run && (cnt_r == CNT_LAST);
  assign product = prod_r;

  // Operand shift registers, accumulating product and step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {MUL_CYCLES{1'b0}};
      prod_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (start) begin
      mcand_r  <= {{(WIDTH-MUL_CYCLES){1'b0}}, a};
      mplier_r <= b;
      prod_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (run) begin
      if (mplier_r[0]) begin
        prod_r <= prod_r + mcand_r;
      end else begin
        prod_r <= prod_r;
      end
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[MUL_CYCLES-1:1]};
      cnt_r    <= cnt_r + CNT_ONE;
    end else begin
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      prod_r   <= prod_r;
      cnt_r    <= cnt_r;
    end
  end

endmodule

// File: rtl/risc_exec_unit.sv
// risc_exec_unit: execute stage. Combinational ALU/shifter feeding a result and
// flag register; Bus_F doubles as the Bus_Dprime forwarding value, so it only
// changes when a result is written.
//   in_valid/in_ready : operation handshake (in_ready low while a MUL runs)
//   Bus_A, Bus_B, FS, SH : operands, function select, shift amount
//   flush             : squash pending/in-flight op, outputs hold
//   out_valid         : one-cycle pulse per completed op
//   Bus_F, N, Z, C, V, illegal : registered result and status
// Build option: RISC_MUL_EN adds the iterative multiplier (FS=11100); without
// it that code decodes as illegal and in_ready is tied high.
module risc_exec_unit
  import risc_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Bus_A,
  input  logic [WIDTH-1:0] Bus_B,
  input  logic [4:0]       FS,
  input  logic [4:0]       SH,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] Bus_F,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             illegal
);

  logic [WIDTH-1:0] add_b_s;
  logic             cin_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shr_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH-1:0] res_s;
  logic             c_s;
  logic             v_s;
  logic             ill_s;
  flags_t           alu_flags_s;

  logic             load_alu_s;
  logic             load_mul_s;
  logic [WIDTH-1:0] mul_prod_s;

  logic [WIDTH-1:0] bus_f_r;
  flags_t           flags_r;
  logic             illegal_r;
  logic             out_valid_r;

  // ALU and shifter. The shifts run one bit wider so the last bit shifted out
  // lands in the spare bit; SH=0 leaves that bit zero.
  always_comb begin
    add_b_s = {WIDTH{1'b0}};
    cin_s   = 1'b0;
    case (FS)
      FS_INC:  begin add_b_s = {WIDTH{1'b0}}; cin_s = 1'b1; end
      FS_ADD:  begin add_b_s = Bus_B;         cin_s = 1'b0; end
      FS_SUB:  begin add_b_s = ~Bus_B;        cin_s = 1'b1; end
      FS_DEC:  begin add_b_s = {WIDTH{1'b1}}; cin_s = 1'b0; end
      default: begin add_b_s = {WIDTH{1'b0}}; cin_s = 1'b0; end
    endcase
    sum_s = {1'b0, Bus_A} + {1'b0, add_b_s} + {{WIDTH{1'b0}}, cin_s};
    shr_s = {Bus_B, 1'b0} >> SH;
    shl_s = {1'b0, Bus_B} << SH;

    res_s = {WIDTH{1'b0}};
    c_s   = 1'b0;
    v_s   = 1'b0;
    ill_s = 1'b0;
    case (FS)
      FS_MOVA: res_s = Bus_A;
      FS_INC, FS_ADD, FS_SUB, FS_DEC: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (Bus_A[WIDTH-1] == add_b_s[WIDTH-1]) && (sum_s[WIDTH-1] != Bus_A[WIDTH-1]);
      end
      FS_AND:  res_s = Bus_A & Bus_B;
      FS_OR:   res_s = Bus_A | Bus_B;
      FS_XOR:  res_s = Bus_A ^ Bus_B;
      FS_NOT:  res_s = ~Bus_A;
      FS_MOVB: res_s = Bus_B;
      FS_LSR:  begin res_s = shr_s[WIDTH:1];   c_s = shr_s[0];     end
      FS_LSL:  begin res_s = shl_s[WIDTH-1:0]; c_s = shl_s[WIDTH]; end
      default: ill_s = 1'b1;
    endcase
    alu_flags_s   = plain_flags(res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}));
    alu_flags_s.c = c_s;
    alu_flags_s.v = v_s;
  end

`ifdef RISC_MUL_EN
  state_t state_r;
  state_t state_nx_s;
  logic   in_ready_r;
  logic   is_mul_s;
  logic   mul_start_s;
  logic   mul_run_s;
  logic   mul_done_s;

  assign is_mul_s   = (FS == FS_MUL);
  assign load_alu_s = in_valid && in_ready_r && !flush && !is_mul_s;
  assign load_mul_s = (state_r == ST_DONE) && !flush;
  assign in_ready   = in_ready_r;

  // Sequencer next state; flush overrides everything and returns to IDLE.
  always_comb begin
    state_nx_s  = state_r;
    mul_start_s = 1'b0;
    mul_run_s   = 1'b0;
    if (flush) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && is_mul_s) begin
            state_nx_s  = ST_MUL_RUN;
            mul_start_s = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_MUL_RUN: begin
          mul_run_s = 1'b1;
          if (mul_done_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_MUL_RUN;
          end
        end
        ST_DONE: state_nx_s = ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State register; in_ready is registered from the next state so it rises
  // together with out_valid when the product is written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= (state_nx_s == ST_IDLE);
    end
  end

  risc_mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .run     (mul_run_s),
    .a       (Bus_A[MUL_CYCLES-1:0]),
    .b       (Bus_B[MUL_CYCLES-1:0]),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );
`else
  assign in_ready   = 1'b1;
  assign load_alu_s = in_valid && !flush;
  assign load_mul_s = 1'b0;
  assign mul_prod_s = {WIDTH{1'b0}};
`endif

  // Result/flag register: written only on a completed op, otherwise held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_f_r     <= {WIDTH{1'b0}};
      flags_r     <= 4'b0000;
      illegal_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (load_alu_s) begin
      bus_f_r     <= res_s;
      flags_r     <= alu_flags_s;
      illegal_r   <= ill_s;
      out_valid_r <= 1'b1;
    end else if (load_mul_s) begin
      bus_f_r     <= mul_prod_s;
      flags_r     <= plain_flags(mul_prod_s[WIDTH-1], (mul_prod_s == {WIDTH{1'b0}}));
      illegal_r   <= 1'b0;
      out_valid_r <= 1'b1;
    end else begin
      bus_f_r     <= bus_f_r;
      flags_r     <= flags_r;
      illegal_r   <= illegal_r;
      out_valid_r <= 1'b0;
    end
  end

  assign Bus_F     = bus_f_r;
  assign N         = flags_r.n;
  assign Z         = flags_r.z;
  assign C         = flags_r.c;
  assign V         = flags_r.v;
  assign illegal   = illegal_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_risc_exec_unit.sv
// tb_risc_exec_unit: directed self-checking bench for risc_exec_unit.
// Multiplier scenarios are compiled when RISC_MUL_EN is defined; otherwise the
// MUL opcode is checked as illegal.
module tb_risc_exec_unit;

  localparam int W  = 32;
  localparam int MC = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  Bus_A;
  logic [W-1:0]  Bus_B;
  logic [4:0]    FS;
  logic [4:0]    SH;
  logic          flush;
  logic          out_valid;
  logic [W-1:0]  Bus_F;
  logic          N, Z, C, V;
  logic          illegal;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  risc_exec_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Bus_A     (Bus_A),
    .Bus_B     (Bus_B),
    .FS        (FS),
    .SH        (SH),
    .flush     (flush),
    .out_valid (out_valid),
    .Bus_F     (Bus_F),
    .N         (N),
    .Z         (Z),
    .C         (C),
    .V         (V),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nzcv();
    return {28'd0, N, Z, C, V};
  endfunction

  // Present one op for one clock edge, then sample 1 time unit after the edge.
  task automatic do_op(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic fl);
    @(negedge clk);
    in_valid = 1'b1; FS = fs; Bus_A = a; Bus_B = b; SH = sh; flush = fl;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [4:0] fs, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp_f,
                          input logic [3:0] exp_fl, input logic exp_ill);
    do_op(fs, a, b, sh, 1'b0);
    check({tag, "_f"},     Bus_F, exp_f);
    check({tag, "_nzcv"},  nzcv(), {28'd0, exp_fl});
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_ill"},   {31'd0, illegal}, {31'd0, exp_ill});
  endtask

`ifdef RISC_MUL_EN
  // MUL with in_valid held until the result appears; checks latency, stall and hold of Bus_F.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_p, input logic [3:0] exp_fl);
    logic [31:0] prev;
    int edges;
    int bad;
    logic seen;
    @(negedge clk);
    in_valid = 1'b1; FS = 5'b11100; Bus_A = a; Bus_B = b; SH = 5'd0; flush = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rdy_low"}, {31'd0, in_ready}, 32'd0);
    prev = Bus_F; edges = 0; bad = 0; seen = 1'b0;
    while (edges < 40 && !seen) begin
      @(posedge clk);
      #1;
      edges++;
      if (out_valid) seen = 1'b1;
      else if (in_ready || Bus_F !== prev) bad++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, edges, MC + 1);
    check({tag, "_stall"},   bad, 32'd0);
    check({tag, "_f"},       Bus_F, exp_p);
    check({tag, "_nzcv"},    nzcv(), {28'd0, exp_fl});
    check({tag, "_rdy_up"},  {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_pulse"},   {31'd0, out_valid}, 32'd0);
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
  endtask
`endif

  initial begin
    logic [31:0] hold;
    int          nv;
    rst_n = 1'b0; in_valid = 1'b0; Bus_A = 32'd0; Bus_B = 32'd0;
    FS = 5'd0; SH = 5'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_f",     Bus_F, 32'd0);
    check("rst_nzcv",  nzcv(), 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_ill",   {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;

    op_check("add_ovf",  5'b00010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 4'b1001, 1'b0);
    // Bus_F and flags hold, out_valid drops when no op is accepted
    @(posedge clk);
    #1;
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_hold",  Bus_F, 32'h8000_0000);
    op_check("sub_eq",   5'b00101, 32'd5, 32'd5, 5'd0, 32'h0000_0000, 4'b0110, 1'b0);
    op_check("lsl_c",    5'b11000, 32'd0, 32'h8000_0001, 5'd1, 32'h0000_0002, 4'b0010, 1'b0);
    op_check("lsr_sh0",  5'b10100, 32'd0, 32'h0000_0003, 5'd0, 32'h0000_0003, 4'b0000, 1'b0);
    op_check("lsr_c",    5'b10100, 32'd0, 32'h0000_0003, 5'd2, 32'h0000_0000, 4'b0110, 1'b0);
    op_check("inc_wrap", 5'b00001, 32'hFFFF_FFFF, 32'd0, 5'd0, 32'h0000_0000, 4'b0110, 1'b0);
    op_check("dec_zero", 5'b00110, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 4'b1000, 1'b0);
    op_check("and",      5'b01000, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 32'h0F0F_0000, 4'b0000, 1'b0);
    op_check("or",       5'b01010, 32'h0000_00F0, 32'h0000_000F, 5'd0, 32'h0000_00FF, 4'b0000, 1'b0);
    op_check("xor",      5'b01100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 4'b0000, 1'b0);
    op_check("not",      5'b01110, 32'h0000_FFFF, 32'd0, 5'd0, 32'hFFFF_0000, 4'b1000, 1'b0);
    op_check("movb",     5'b10000, 32'h1234_5678, 32'd0, 5'd0, 32'h0000_0000, 4'b0100, 1'b0);
    op_check("mova",     5'b00000, 32'h8000_0000, 32'h5, 5'd0, 32'h8000_0000, 4'b1000, 1'b0);
    op_check("undef",    5'b00011, 32'h1234_5678, 32'h1, 5'd3, 32'h0000_0000, 4'b0100, 1'b1);
    op_check("after_undef", 5'b00010, 32'd2, 32'd3, 5'd0, 32'h0000_0005, 4'b0000, 1'b0);

    // flush together with in_valid: nothing accepted, outputs hold
    do_op(5'b00010, 32'd100, 32'd200, 5'd0, 1'b1);
    check("flush_op_valid", {31'd0, out_valid}, 32'd0);
    check("flush_op_hold",  Bus_F, 32'h0000_0005);

`ifdef RISC_MUL_EN
    run_mul("mul_ffff", 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 4'b1000);
    run_mul("mul_trunc", 32'h0001_2345, 32'h0001_0003, 32'h0000_69CF, 4'b0000);

    // flush in MUL_RUN cycle 5
    hold = Bus_F;
    @(negedge clk);
    in_valid = 1'b1; FS = 5'b11100; Bus_A = 32'd3; Bus_B = 32'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("mflush_valid", {31'd0, out_valid}, 32'd0);
    check("mflush_ready", {31'd0, in_ready}, 32'd1);
    check("mflush_hold",  Bus_F, hold);
    count_valid(24, nv);
    check("mflush_no_result", nv, 32'd0);

    // reset in the middle of a MUL
    @(negedge clk);
    in_valid = 1'b1; FS = 5'b11100; Bus_A = 32'd7; Bus_B = 32'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst_f",     Bus_F, 32'd0);
    check("mrst_nzcv",  nzcv(), 32'd0);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd1);
    count_valid(24, nv);
    check("mrst_no_result", nv, 32'd0);
    op_check("post_mul", 5'b00010, 32'd1, 32'd1, 5'd0, 32'h0000_0002, 4'b0000, 1'b0);
`else
    op_check("mul_illegal", 5'b11100, 32'h0000_FFFF, 32'h0000_FFFF, 5'd0, 32'h0000_0000, 4'b0100, 1'b1);
    check("mul_illegal_ready", {31'd0, in_ready}, 32'd1);
    op_check("post_mul", 5'b00010, 32'd1, 32'd1, 5'd0, 32'h0000_0002, 4'b0000, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
